cpu_core: RTL and testbench

//  Parametrised accumulator CPU core: fetch/execute sequencer, accumulator, register file, Z/C flags, call stack, interrupt entry.

---
 rtl/cpu_pkg.sv | 73 +++++++
 rtl/cpu_core_if.sv | 38 +++
 rtl/call_stack.sv | 45 ++++
 rtl/cpu_core.sv | 210 +++++++++++++++++++++
 tb/tb_cpu_core.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Opcodes, FSM states and ALU selection shared by the accumulator core.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [7:0] c_OP_NOP  = 8'h00;
  localparam logic [7:0] c_OP_LDI  = 8'h01;
  localparam logic [7:0] c_OP_ADDI = 8'h02;
  localparam logic [7:0] c_OP_SUBI = 8'h03;
  localparam logic [7:0] c_OP_ANDI = 8'h04;
  localparam logic [7:0] c_OP_ORI  = 8'h05;
  localparam logic [7:0] c_OP_XORI = 8'h06;
  localparam logic [7:0] c_OP_LD   = 8'h10;
  localparam logic [7:0] c_OP_ST   = 8'h11;
  localparam logic [7:0] c_OP_ADD  = 8'h12;
  localparam logic [7:0] c_OP_SUB  = 8'h13;
  localparam logic [7:0] c_OP_AND  = 8'h14;
  localparam logic [7:0] c_OP_OR   = 8'h15;
  localparam logic [7:0] c_OP_XOR  = 8'h16;
  localparam logic [7:0] c_OP_IN   = 8'h20;
  localparam logic [7:0] c_OP_OUT  = 8'h21;
  localparam logic [7:0] c_OP_JMP  = 8'h30;
  localparam logic [7:0] c_OP_JZ   = 8'h31;
  localparam logic [7:0] c_OP_JNZ  = 8'h32;
  localparam logic [7:0] c_OP_JC   = 8'h33;
  localparam logic [7:0] c_OP_CALL = 8'h34;
  localparam logic [7:0] c_OP_RET  = 8'h35;
  localparam logic [7:0] c_OP_RETI = 8'h36;
  localparam logic [7:0] c_OP_EI   = 8'h37;
  localparam logic [7:0] c_OP_DI   = 8'h38;
  localparam logic [7:0] c_OP_HALT = 8'h3F;
  localparam logic [7:0] c_OP_RST  = 8'hFF;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXEC    = 2'd1,
    ST_IO_WAIT = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5
  } alu_op_e;

  function automatic alu_op_e alu_sel(input logic [7:0] op);
    case (op)
      c_OP_ADDI, c_OP_ADD: alu_sel = ALU_ADD;
      c_OP_SUBI, c_OP_SUB: alu_sel = ALU_SUB;
      c_OP_ANDI, c_OP_AND: alu_sel = ALU_AND;
      c_OP_ORI,  c_OP_OR:  alu_sel = ALU_OR;
      c_OP_XORI, c_OP_XOR: alu_sel = ALU_XOR;
      default:             alu_sel = ALU_PASS;
    endcase
  endfunction

  function automatic logic op_legal(input logic [7:0] op);
    op_legal = (op == c_OP_NOP) || (op >= c_OP_LDI && op <= c_OP_XORI) ||
               (op >= c_OP_LD && op <= c_OP_XOR) || (op == c_OP_IN) || (op == c_OP_OUT) ||
               (op >= c_OP_JMP && op <= c_OP_DI) || (op == c_OP_HALT) || (op == c_OP_RST);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_core_if.sv
// ============================================================================
// Module : cpu_core_if
// Brief  : Instruction ROM, I/O bus, interrupt and status signals of cpu_core.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface cpu_core_if #(
  parameter int WIDTH        = 16,
  parameter int PC_BITS      = 8,
  parameter int IO_ADDR_BITS = 4
);
  logic [PC_BITS-1:0]      imem_addr;
  logic [WIDTH+7:0]        imem_data;
  logic [IO_ADDR_BITS-1:0] io_addr;
  logic [WIDTH-1:0]        io_wdata;
  logic                    io_we;
  logic                    io_re;
  logic [WIDTH-1:0]        io_rdata;
  logic                    io_ready;
  logic                    irq;
  logic                    irq_ack;
  logic                    halted;
  logic                    err;
  logic [WIDTH-1:0]        out;

  modport master (
    output imem_addr, io_addr, io_wdata, io_we, io_re, irq_ack, halted, err, out,
    input  imem_data, io_rdata, io_ready, irq
  );

  modport slave (
    input  imem_addr, io_addr, io_wdata, io_we, io_re, irq_ack, halted, err, out,
    output imem_data, io_rdata, io_ready, irq
  );
endinterface

`default_nettype wire

// File: rtl/call_stack.sv
// ============================================================================
// Module : call_stack
// Brief  : LIFO of return addresses; data_out shows the top entry.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module call_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [WIDTH-1:0] data_in,
  output logic      [WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);
  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_CW-1:0]  r_count;
  logic [c_CW-1:0]  w_top;

  assign full     = (r_count == c_CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign w_top    = r_count - c_CW'(1);
  assign data_out = empty ? '0 : r_mem[c_AW'(w_top)];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (push && !full) begin
      r_mem[c_AW'(r_count)] <= data_in;
      r_count               <= r_count + c_CW'(1);
    end else if (pop && !empty) begin
      r_count <= w_top;
    end
  end
endmodule

`default_nettype wire

// File: rtl/cpu_core.sv
// ============================================================================
// Module : cpu_core
// Brief  : Accumulator CPU: fetch/exec sequencer, register file, Z/C, calls, IRQ.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cpu_core
  import cpu_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int PC_BITS       = 8,
  parameter int REG_ADDR_BITS = 4,
  parameter int IO_ADDR_BITS  = 4,
  parameter int STACK_DEPTH   = 8,
  parameter int RESET_VEC     = 0,
  parameter int IRQ_VEC       = 4
) (
  input wire logic   clk_in,
  input wire logic   rst_in,
  cpu_core_if.master bus
);
  localparam int                 c_NREGS    = 2 ** REG_ADDR_BITS;
  localparam logic [PC_BITS-1:0] c_RESET_PC = PC_BITS'(RESET_VEC);
  localparam logic [PC_BITS-1:0] c_IRQ_PC   = PC_BITS'(IRQ_VEC);

  state_e                  r_state;
  logic [PC_BITS-1:0]      r_pc;
  logic [WIDTH-1:0]        r_acc;
  logic [WIDTH-1:0]        r_regs [c_NREGS];
  logic                    r_z, r_c, r_ie, r_err, r_irq_ack, r_io_wr;
  logic [IO_ADDR_BITS-1:0] r_io_addr;

  logic [7:0]               w_op;
  logic [WIDTH-1:0]         w_imm, w_operand, w_alu_res;
  logic                     w_alu_c, w_acc_op;
  logic [REG_ADDR_BITS-1:0] w_reg_idx;
  logic [PC_BITS-1:0]       w_target, w_pc_inc, w_next_pc, w_stk_top, w_push_data;
  logic                     w_exec, w_soft_rst, w_is_io, w_stack_op, w_irq_take, w_halt_wake;
  logic                     w_push, w_pop, w_full, w_empty, w_stk_rst;

  assign w_op       = bus.imem_data[WIDTH+7:WIDTH];
  assign w_imm      = bus.imem_data[WIDTH-1:0];
  assign w_reg_idx  = w_imm[REG_ADDR_BITS-1:0];
  assign w_target   = w_imm[PC_BITS-1:0];
  assign w_pc_inc   = r_pc + PC_BITS'(1);
  assign w_operand  = w_op[4] ? r_regs[w_reg_idx] : w_imm;
  assign w_exec     = (r_state == ST_EXEC);
  assign w_soft_rst = w_exec && (w_op == c_OP_RST);
  assign w_is_io    = w_exec && ((w_op == c_OP_IN) || (w_op == c_OP_OUT));
  assign w_stack_op = (w_op == c_OP_CALL) || (w_op == c_OP_RET) || (w_op == c_OP_RETI);
  assign w_acc_op   = (w_op >= c_OP_LDI && w_op <= c_OP_XORI) || (w_op == c_OP_LD) ||
                      (w_op >= c_OP_ADD && w_op <= c_OP_XOR);
  assign w_stk_rst  = rst_in || w_soft_rst;

  // Interrupts are deferred past stack-using instructions so push/pop never collide.
  assign w_irq_take  = w_exec && bus.irq && r_ie && !w_full && !w_stack_op &&
                       (w_op != c_OP_HALT) && (w_op != c_OP_RST) && !(w_is_io && !bus.io_ready);
  assign w_halt_wake = (r_state == ST_HALT) && bus.irq && r_ie && !w_full;

  always_comb begin
    w_alu_res = w_operand;
    w_alu_c   = r_c;
    case (alu_sel(w_op))
      ALU_ADD: {w_alu_c, w_alu_res} = {1'b0, r_acc} + {1'b0, w_operand};
      ALU_SUB: begin
        w_alu_res = r_acc - w_operand;
        w_alu_c   = (r_acc < w_operand);
      end
      ALU_AND: begin w_alu_res = r_acc & w_operand; w_alu_c = 1'b0; end
      ALU_OR:  begin w_alu_res = r_acc | w_operand; w_alu_c = 1'b0; end
      ALU_XOR: begin w_alu_res = r_acc ^ w_operand; w_alu_c = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    w_next_pc = w_pc_inc;
    case (w_op)
      c_OP_JMP:  w_next_pc = w_target;
      c_OP_JZ:   if (r_z)      w_next_pc = w_target;
      c_OP_JNZ:  if (!r_z)     w_next_pc = w_target;
      c_OP_JC:   if (r_c)      w_next_pc = w_target;
      c_OP_CALL: if (!w_full)  w_next_pc = w_target;
      c_OP_RET, c_OP_RETI: if (!w_empty) w_next_pc = w_stk_top;
      default: ;
    endcase
  end

  always_comb begin
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_push_data = w_pc_inc;
    if (w_exec && (w_op == c_OP_CALL) && !w_full) w_push = 1'b1;
    if (w_exec && ((w_op == c_OP_RET) || (w_op == c_OP_RETI)) && !w_empty) w_pop = 1'b1;
    if (w_irq_take) begin
      w_push      = 1'b1;
      w_push_data = w_next_pc;
    end
    if (w_halt_wake) begin
      w_push      = 1'b1;
      w_push_data = r_pc;
    end
  end

  call_stack #(
    .WIDTH (PC_BITS),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk      (clk_in),
    .rst      (w_stk_rst),
    .push     (w_push),
    .pop      (w_pop),
    .data_in  (w_push_data),
    .data_out (w_stk_top),
    .full     (w_full),
    .empty    (w_empty)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in || w_soft_rst) begin
      r_state   <= ST_FETCH;
      r_pc      <= c_RESET_PC;
      r_acc     <= '0;
      r_z       <= 1'b0;
      r_c       <= 1'b0;
      r_ie      <= 1'b0;
      r_err     <= 1'b0;
      r_irq_ack <= 1'b0;
      r_io_wr   <= 1'b0;
      r_io_addr <= '0;
      for (int i = 0; i < c_NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_irq_ack <= 1'b0;
      case (r_state)
        ST_FETCH: r_state <= ST_EXEC;
        ST_EXEC: begin
          r_state <= ST_FETCH;
          r_pc    <= w_next_pc;
          if (w_acc_op) begin
            r_acc <= w_alu_res;
            r_z   <= (w_alu_res == '0);
            r_c   <= w_alu_c;
          end
          if (!op_legal(w_op)) r_err <= 1'b1;
          case (w_op)
            c_OP_ST: r_regs[w_reg_idx] <= r_acc;
            c_OP_IN, c_OP_OUT: begin
              if (bus.io_ready) begin
                if (w_op == c_OP_IN) begin
                  r_acc <= bus.io_rdata;
                  r_z   <= (bus.io_rdata == '0);
                end
              end else begin
                r_state   <= ST_IO_WAIT;
                r_pc      <= r_pc;
                r_io_wr   <= (w_op == c_OP_OUT);
                r_io_addr <= w_imm[IO_ADDR_BITS-1:0];
              end
            end
            c_OP_CALL: if (w_full)  r_err <= 1'b1;
            c_OP_RET:  if (w_empty) r_err <= 1'b1;
            c_OP_RETI: if (w_empty) r_err <= 1'b1; else r_ie <= 1'b1;
            c_OP_EI:   r_ie    <= 1'b1;
            c_OP_DI:   r_ie    <= 1'b0;
            c_OP_HALT: r_state <= ST_HALT;
            default: ;
          endcase
          if (w_irq_take) begin
            r_pc      <= c_IRQ_PC;
            r_ie      <= 1'b0;
            r_irq_ack <= 1'b1;
          end
        end
        ST_IO_WAIT: begin
          if (bus.io_ready) begin
            if (!r_io_wr) begin
              r_acc <= bus.io_rdata;
              r_z   <= (bus.io_rdata == '0);
            end
            r_pc    <= w_pc_inc;
            r_state <= ST_FETCH;
          end
        end
        ST_HALT: begin
          if (w_halt_wake) begin
            r_pc      <= c_IRQ_PC;
            r_ie      <= 1'b0;
            r_irq_ack <= 1'b1;
            r_state   <= ST_FETCH;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  // Requests are raised combinationally in EXEC so a ready peripheral costs no wait state.
  assign bus.io_we     = (w_exec && (w_op == c_OP_OUT)) || ((r_state == ST_IO_WAIT) && r_io_wr);
  assign bus.io_re     = (w_exec && (w_op == c_OP_IN))  || ((r_state == ST_IO_WAIT) && !r_io_wr);
  assign bus.io_addr   = (r_state == ST_IO_WAIT) ? r_io_addr : w_imm[IO_ADDR_BITS-1:0];
  assign bus.io_wdata  = r_acc;
  assign bus.imem_addr = r_pc;
  assign bus.irq_ack   = r_irq_ack;
  assign bus.halted    = (r_state == ST_HALT);
  assign bus.err       = r_err;
  assign bus.out       = r_acc;
endmodule

`default_nettype wire

// File: tb/tb_cpu_core.sv
// ============================================================================
// Module : tb_cpu_core
// Brief  : Directed program for cpu_core with hand-computed expected values.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_core;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   we_cnt;
  logic [23:0] rom [256];
  logic [7:0]  ret_pc [8];

  cpu_core_if #(.WIDTH(16), .PC_BITS(8), .IO_ADDR_BITS(4)) bus ();

  cpu_core #(
    .WIDTH(16), .PC_BITS(8), .REG_ADDR_BITS(4), .IO_ADDR_BITS(4),
    .STACK_DEPTH(8), .RESET_VEC(0), .IRQ_VEC(4)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

  function automatic logic [23:0] ins(input logic [7:0] op, input logic [15:0] imm);
    return {op, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  // One plain instruction is FETCH + EXEC; sampling lands in the next FETCH.
  task automatic step(input string tag, input logic [7:0] exp_pc, input logic [15:0] exp_out);
    cyc(2);
    check({tag, "_pc"}, bus.imem_addr, exp_pc);
    check({tag, "_out"}, bus.out, exp_out);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[8'h00] = ins(c_OP_JMP, 16'h0010);
    rom[8'h04] = ins(c_OP_RETI, 16'h0000);
    rom[8'h10] = ins(c_OP_LDI, 16'hFFFF);
    rom[8'h11] = ins(c_OP_ADDI, 16'h0001);
    rom[8'h12] = ins(c_OP_JC, 16'h0014);
    rom[8'h14] = ins(c_OP_JZ, 16'h0016);
    rom[8'h16] = ins(c_OP_SUBI, 16'h0001);
    rom[8'h17] = ins(c_OP_JC, 16'h0019);
    rom[8'h19] = ins(c_OP_JNZ, 16'h001B);
    rom[8'h1B] = ins(c_OP_LDI, 16'h0005);
    rom[8'h1C] = ins(c_OP_ST, 16'h0003);
    rom[8'h1D] = ins(c_OP_LDI, 16'h0000);
    rom[8'h1E] = ins(c_OP_ADD, 16'h0003);
    rom[8'h1F] = ins(c_OP_JZ, 16'h0030);
    rom[8'h20] = ins(c_OP_JC, 16'h0030);
    rom[8'h21] = ins(c_OP_SUBI, 16'h0005);
    rom[8'h22] = ins(c_OP_JZ, 16'h0030);
    rom[8'h30] = ins(c_OP_XORI, 16'h00FF);
    rom[8'h31] = ins(c_OP_ORI, 16'h0F00);
    rom[8'h32] = ins(c_OP_ANDI, 16'h00F0);
    rom[8'h33] = ins(c_OP_ADDI, 16'h0100);
    rom[8'h34] = ins(c_OP_XOR, 16'h0003);
    rom[8'h35] = ins(c_OP_CALL, 16'h0040);
    for (int i = 0; i < 7; i++) begin
      rom[8'h40 + 2*i]     = ins(c_OP_CALL, 16'(8'h42 + 2*i));
      rom[8'h40 + 2*i + 1] = ins(c_OP_RET, 16'h0000);
    end
    rom[8'h4E] = ins(c_OP_CALL, 16'h0060);
    rom[8'h4F] = ins(c_OP_RET, 16'h0000);
    rom[8'h36] = ins(c_OP_OUT, 16'h0002);
    rom[8'h37] = ins(c_OP_IN, 16'h0005);
    rom[8'h38] = ins(c_OP_IN, 16'h0006);
    rom[8'h39] = ins(c_OP_EI, 16'h0000);
    rom[8'h3A] = ins(c_OP_HALT, 16'h0000);
    rom[8'h3C] = ins(c_OP_DI, 16'h0000);
    rom[8'h3D] = ins(c_OP_HALT, 16'h0000);

    rst = 1'b1; bus.io_ready = 1'b0; bus.io_rdata = '0; bus.irq = 1'b0;
    cyc(3);
    check("rst_pc", bus.imem_addr, 8'h00);
    check("rst_out", bus.out, 16'h0000);
    check("rst_halted", bus.halted, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_io_we", bus.io_we, 1'b0);
    check("rst_io_re", bus.io_re, 1'b0);
    check("rst_irq_ack", bus.irq_ack, 1'b0);
    rst = 1'b0;

    step("jmp", 8'h10, 16'h0000);
    step("ldi_ffff", 8'h11, 16'hFFFF);
    step("addi_wrap", 8'h12, 16'h0000);
    step("jc_carry", 8'h14, 16'h0000);
    step("jz_zero", 8'h16, 16'h0000);
    step("subi_borrow", 8'h17, 16'hFFFF);
    step("jc_borrow", 8'h19, 16'hFFFF);
    step("jnz_taken", 8'h1B, 16'hFFFF);
    cyc(6);
    check("ldi0_out", bus.out, 16'h0000);
    step("add_r3", 8'h1F, 16'h0005);
    step("jz_untaken", 8'h20, 16'h0005);
    step("jc_untaken", 8'h21, 16'h0005);
    step("subi_zero", 8'h22, 16'h0000);
    step("jz_taken", 8'h30, 16'h0000);
    step("xori", 8'h31, 16'h00FF);
    step("ori", 8'h32, 16'h0FFF);
    step("andi", 8'h33, 16'h00F0);
    step("addi", 8'h34, 16'h01F0);
    step("xor_r3", 8'h35, 16'h01F5);

    step("call1", 8'h40, 16'h01F5);
    cyc(14);
    check("call8_pc", bus.imem_addr, 8'h4E);
    check("call8_err", bus.err, 1'b0);
    step("call_full", 8'h4F, 16'h01F5);
    check("call_full_err", bus.err, 1'b1);
    ret_pc = '{8'h4D, 8'h4B, 8'h49, 8'h47, 8'h45, 8'h43, 8'h41, 8'h36};
    for (int i = 0; i < 8; i++) step($sformatf("ret%0d", i), ret_pc[i], 16'h01F5);

    // OUT 2 with three not-ready cycles
    cyc(1);
    check("out_we_exec", bus.io_we, 1'b1);
    check("out_addr", bus.io_addr, 4'h2);
    check("out_wdata", bus.io_wdata, 16'h01F5);
    check("out_re", bus.io_re, 1'b0);
    we_cnt = 1;
    repeat (2) begin cyc(1); if (bus.io_we) we_cnt++; end
    check("out_addr_wait", bus.io_addr, 4'h2);
    bus.io_ready = 1'b1;
    if (bus.io_we) we_cnt++;
    cyc(1);
    bus.io_ready = 1'b0;
    check("out_we_cycles", we_cnt, 4);
    check("out_we_drop", bus.io_we, 1'b0);
    check("out_pc", bus.imem_addr, 8'h37);

    // IN 5 with zero wait
    bus.io_ready = 1'b1; bus.io_rdata = 16'h1234;
    cyc(1);
    check("in0_re", bus.io_re, 1'b1);
    check("in0_addr", bus.io_addr, 4'h5);
    cyc(1);
    bus.io_ready = 1'b0;
    check("in0_out", bus.out, 16'h1234);
    check("in0_pc", bus.imem_addr, 8'h38);
    check("in0_re_drop", bus.io_re, 1'b0);

    // IN 6 with one wait cycle
    bus.io_rdata = 16'h0000;
    cyc(1);
    check("in1_re", bus.io_re, 1'b1);
    check("in1_addr", bus.io_addr, 4'h6);
    cyc(1);
    check("in1_re_wait", bus.io_re, 1'b1);
    check("in1_out_wait", bus.out, 16'h1234);
    bus.io_rdata = 16'hABCD; bus.io_ready = 1'b1;
    cyc(1);
    bus.io_ready = 1'b0;
    check("in1_out", bus.out, 16'hABCD);
    check("in1_pc", bus.imem_addr, 8'h39);

    step("ei", 8'h3A, 16'hABCD);
    step("halt", 8'h3B, 16'hABCD);
    cyc(3);
    check("halt_halted", bus.halted, 1'b1);
    check("halt_pc", bus.imem_addr, 8'h3B);
    bus.irq = 1'b1;
    cyc(1);
    bus.irq = 1'b0;
    check("wake_ack", bus.irq_ack, 1'b1);
    check("wake_halted", bus.halted, 1'b0);
    check("wake_pc", bus.imem_addr, 8'h04);
    step("reti", 8'h3B, 16'hABCD);
    check("reti_ack", bus.irq_ack, 1'b0);
    bus.irq = 1'b1;
    step("irq_exec", 8'h04, 16'hABCD);
    check("irq_exec_ack", bus.irq_ack, 1'b1);
    bus.irq = 1'b0;
    step("reti2", 8'h3C, 16'hABCD);
    step("di", 8'h3D, 16'hABCD);
    step("halt_di", 8'h3E, 16'hABCD);
    bus.irq = 1'b1;
    cyc(3);
    check("halt_di_halted", bus.halted, 1'b1);
    check("halt_di_ack", bus.irq_ack, 1'b0);
    check("halt_di_pc", bus.imem_addr, 8'h3E);
    bus.irq = 1'b0;

    // rst_in while an OUT is waiting
    rst = 1'b1;
    rom[8'h00] = ins(c_OP_LDI, 16'h0077);
    rom[8'h01] = ins(c_OP_OUT, 16'h0009);
    cyc(2);
    check("rst2_halted", bus.halted, 1'b0);
    check("rst2_out", bus.out, 16'h0000);
    rst = 1'b0;
    step("p2_ldi", 8'h01, 16'h0077);
    cyc(1);
    check("p2_we_exec", bus.io_we, 1'b1);
    check("p2_wdata", bus.io_wdata, 16'h0077);
    cyc(1);
    check("p2_we_wait", bus.io_we, 1'b1);
    rst = 1'b1;
    cyc(1);
    check("p2_rst_we", bus.io_we, 1'b0);
    check("p2_rst_re", bus.io_re, 1'b0);
    check("p2_rst_out", bus.out, 16'h0000);
    check("p2_rst_pc", bus.imem_addr, 8'h00);
    rom[8'h01] = ins(8'h07, 16'h0000);
    rom[8'h02] = ins(c_OP_EI, 16'h0000);
    rom[8'h03] = ins(c_OP_RST, 16'h0000);
    rst = 1'b0;

    // Soft reset clears err and ie and ignores a pending irq
    step("p3_ldi", 8'h01, 16'h0077);
    step("illegal", 8'h02, 16'h0077);
    check("illegal_err", bus.err, 1'b1);
    step("p3_ei", 8'h03, 16'h0077);
    bus.irq = 1'b1;
    step("soft_rst", 8'h00, 16'h0000);
    check("soft_rst_err", bus.err, 1'b0);
    check("soft_rst_ack", bus.irq_ack, 1'b0);
    check("soft_rst_halted", bus.halted, 1'b0);
    step("after_soft_rst", 8'h01, 16'h0077);
    check("after_soft_rst_ack", bus.irq_ack, 1'b0);
    bus.irq = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
